// File: rtl/lcg_stim_gen_if.sv
// Output stream of the LCG stimulus generator: word data with a valid/ready handshake.
// The master drives data and valid; the slave drives ready.
interface lcg_stim_gen_if #(
    parameter int OUT_W = 133
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/lcg_stim_gen.sv
// LCG stimulus generator: builds OUT_W-bit words from successive 32-bit LCG states,
// filled LSB-first, and emits a programmable number of words per run.
module lcg_stim_gen #(
    parameter int          OUT_W        = 133,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] DEFAULT_SEED = 32'd2016885264,
    parameter logic [31:0] LCG_MUL      = 32'h41C6_4E6D,
    parameter logic [31:0] LCG_INC      = 32'h0000_3039
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_seed_load,
    input  logic [31:0]      i_seed_val,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_words,
    input  logic             i_stop,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_word_count,
    output logic [31:0]      o_rng_state,
    lcg_stim_gen_if.master   m_stream
);

    localparam int WORDS = (OUT_W + 31) / 32;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SH_W  = WORDS * 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    function automatic logic [31:0] lcg_step(input logic [31:0] s);
        logic [63:0] prod;
        prod = {32'd0, s} * {32'd0, LCG_MUL};
        return prod[31:0] + LCG_INC;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_rng;
    logic [SH_W-1:0]   r_shadow;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_count;
    logic [OUT_W-1:0]  r_data;
    logic              r_valid;
    logic              r_done;
    logic              r_busy;

    logic              w_abort;
    logic              w_seed_ld;
    logic              w_run_start;
    logic              w_step;
    logic              w_accept;
    logic              w_finish;
    logic [31:0]       w_lcg;
    logic [CNT_W-1:0]  w_count_inc;
    logic [SH_W-1:0]   w_shadow_nxt;

    assign w_lcg       = lcg_step(r_rng);
    assign w_count_inc = r_count + CNT_W'(1);

    // Next-state decode and per-cycle action strobes; stop overrides every other request.
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_seed_ld   = 1'b0;
        w_run_start = 1'b0;
        w_step      = 1'b0;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        if (i_stop) begin
            w_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_seed_load) begin
                        w_seed_ld = 1'b1;
                    end else if (i_start) begin
                        w_run_start = 1'b1;
                        w_state_nxt = (i_num_words == {CNT_W{1'b0}}) ? ST_DONE : ST_FILL;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_FILL: begin
                    w_step = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_PRESENT;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
                ST_PRESENT: begin
                    if (m_stream.out_ready) begin
                        w_accept = 1'b1;
                        if (w_count_inc == r_num) begin
                            w_finish    = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_FILL;
                        end
                    end else begin
                        w_state_nxt = ST_PRESENT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Shadow word with the current chunk replaced, so the last chunk reaches out_data in the same cycle.
    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_shadow_nxt[k*32 +: 32] = w_lcg;
            end else begin
                w_shadow_nxt[k*32 +: 32] = r_shadow[k*32 +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: LCG state, chunk assembly, handshake, run bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rng    <= DEFAULT_SEED;
            r_shadow <= {SH_W{1'b0}};
            r_idx    <= {IDX_W{1'b0}};
            r_num    <= {CNT_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_data   <= {OUT_W{1'b0}};
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_PRESENT);
            if (w_abort) begin
                r_valid <= 1'b0;
            end
            if (w_seed_ld) begin
                r_rng  <= i_seed_val;
                r_done <= 1'b0;
            end
            if (w_run_start) begin
                r_num   <= i_num_words;
                r_count <= {CNT_W{1'b0}};
                r_done  <= (i_num_words == {CNT_W{1'b0}});
                r_idx   <= {IDX_W{1'b0}};
            end
            if (w_step) begin
                r_rng    <= w_lcg;
                r_shadow <= w_shadow_nxt;
                if (r_idx == LAST_IDX) begin
                    r_data  <= w_shadow_nxt[OUT_W-1:0];
                    r_valid <= 1'b1;
                    r_idx   <= {IDX_W{1'b0}};
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            if (w_accept) begin
                r_count <= w_count_inc;
                r_valid <= 1'b0;
                if (w_finish) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign m_stream.out_data  = r_data;
    assign m_stream.out_valid = r_valid;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_word_count       = r_count;
    assign o_rng_state        = r_rng;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Scoreboard bench for lcg_stim_gen: a 133-bit instance driven through directed runs
// and a 32-bit instance checked for the one-step-per-word case.
module tb_lcg_stim_gen;

    localparam int OUT_W = 133;
    localparam int CNT_W = 16;
    localparam logic [31:0] DEF_SEED = 32'd2016885264;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             seed_load, start, stop;
    logic [31:0]      seed_val;
    logic [CNT_W-1:0] num_words;
    logic             busy, done;
    logic [CNT_W-1:0] word_count;
    logic [31:0]      rng_state;

    logic             seed_load32, start32, stop32;
    logic [31:0]      seed_val32;
    logic [CNT_W-1:0] num_words32;
    logic             busy32, done32;
    logic [CNT_W-1:0] word_count32;
    logic [31:0]      rng_state32;

    lcg_stim_gen_if #(.OUT_W(OUT_W)) s_if ();
    lcg_stim_gen_if #(.OUT_W(32))    s32_if ();

    lcg_stim_gen #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(seed_load), .i_seed_val(seed_val),
        .i_start(start), .i_num_words(num_words), .i_stop(stop), .o_busy(busy),
        .o_done(done), .o_word_count(word_count), .o_rng_state(rng_state),
        .m_stream(s_if.master)
    );

    lcg_stim_gen #(.OUT_W(32), .CNT_W(CNT_W)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_seed_load(seed_load32), .i_seed_val(seed_val32),
        .i_start(start32), .i_num_words(num_words32), .i_stop(stop32), .o_busy(busy32),
        .o_done(done32), .o_word_count(word_count32), .o_rng_state(rng_state32),
        .m_stream(s32_if.master)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [31:0]      exp32_q[$];
    logic [31:0]      model_state;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lcg(input logic [31:0] s);
        logic [63:0] p;
        p = 64'(s) * 64'(32'h41C6_4E6D);
        return p[31:0] + 32'h0000_3039;
    endfunction

    task automatic push_words(input int n);
        logic [159:0] w;
        for (int i = 0; i < n; i++) begin
            w = 160'd0;
            for (int c = 0; c < 5; c++) begin
                model_state = lcg(model_state);
                w[c*32 +: 32] = model_state;
            end
            exp_q.push_back(w[OUT_W-1:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lim);
        int i;
        i = 0;
        while (!s_if.out_valid && i < lim) begin
            tick();
            i++;
        end
        check("valid_within_bound", {132'd0, s_if.out_valid}, {132'd0, 1'b1});
    endtask

    task automatic wait_done(input int lim);
        int i;
        i = 0;
        while (!done && i < lim) begin
            tick();
            i++;
        end
        check("done_within_bound", {132'd0, done}, {132'd0, 1'b1});
    endtask

    // Scoreboard monitor for the 133-bit instance: pop on every accepted word.
    always @(negedge clk) begin
        if (rst_n && s_if.out_valid && s_if.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %h expected none", s_if.out_data);
            end else begin
                check("word", s_if.out_data, exp_q.pop_front());
            end
        end
    end

    // Scoreboard monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (rst_n && s32_if.out_valid && s32_if.out_ready) begin
            if (exp32_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word32: got %h expected none", s32_if.out_data);
            end else begin
                check("word32", {101'd0, s32_if.out_data}, {101'd0, exp32_q.pop_front()});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [OUT_W-1:0] held_data;
        logic [31:0]      held_rng;

        rst_n = 1'b0; seed_load = 1'b0; start = 1'b0; stop = 1'b0;
        seed_val = 32'd0; num_words = '0; s_if.out_ready = 1'b0;
        seed_load32 = 1'b0; start32 = 1'b0; stop32 = 1'b0;
        seed_val32 = 32'd0; num_words32 = '0; s32_if.out_ready = 1'b0;
        tick(); tick();
        check("rst_data",  s_if.out_data, '0);
        check("rst_valid", {132'd0, s_if.out_valid}, '0);
        check("rst_busy",  {132'd0, busy}, '0);
        check("rst_done",  {132'd0, done}, '0);
        check("rst_count", {117'd0, word_count}, '0);
        check("rst_rng",   {101'd0, rng_state}, {101'd0, DEF_SEED});
        rst_n = 1'b1;
        tick();

        // Seed 0, one word: valid 5 cycles after start.
        seed_load = 1'b1; seed_val = 32'd0;
        tick();
        seed_load = 1'b0;
        check("seed_rng", {101'd0, rng_state}, '0);
        model_state = 32'd0;
        push_words(1);
        start = 1'b1; num_words = 16'd1; s_if.out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("valid_not_early", {132'd0, s_if.out_valid}, '0);
        tick();
        check("valid_at_5", {132'd0, s_if.out_valid}, {132'd0, 1'b1});
        check("chunk0", {101'd0, s_if.out_data[31:0]},  {101'd0, 32'h0000_3039});
        check("chunk1", {101'd0, s_if.out_data[63:32]}, {101'd0, 32'hD3DC_167E});
        tick();
        check("one_done",  {132'd0, done}, {132'd0, 1'b1});
        check("one_count", {117'd0, word_count}, {117'd0, 16'd1});
        check("one_busy",  {132'd0, busy}, '0);

        // Default seed after reset, 150 words.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_state = DEF_SEED;
        push_words(150);
        start = 1'b1; num_words = 16'd150;
        tick();
        start = 1'b0;
        wait_done(2000);
        check("run150_count", {117'd0, word_count}, {117'd0, 16'd150});
        check("run150_drained", OUT_W'(exp_q.size()), '0);

        // Backpressure: word held 10 cycles, stream continues afterwards.
        s_if.out_ready = 1'b0;
        push_words(2);
        start = 1'b1; num_words = 16'd2;
        tick();
        start = 1'b0;
        wait_valid(20);
        held_data = s_if.out_data;
        held_rng  = rng_state;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_data",  s_if.out_data, held_data);
            check("bp_valid", {132'd0, s_if.out_valid}, {132'd0, 1'b1});
            check("bp_rng",   {101'd0, rng_state}, {101'd0, held_rng});
        end
        s_if.out_ready = 1'b1;
        wait_done(50);
        check("bp_count", {117'd0, word_count}, {117'd0, 16'd2});

        // Abort after three chunks have been generated.
        start = 1'b1; num_words = 16'd3;
        tick();
        start = 1'b0;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 3; i++) model_state = lcg(model_state);
        check("abort_valid", {132'd0, s_if.out_valid}, '0);
        check("abort_busy",  {132'd0, busy}, '0);
        check("abort_done",  {132'd0, done}, '0);
        check("abort_rng",   {101'd0, rng_state}, {101'd0, model_state});
        push_words(1);
        start = 1'b1; num_words = 16'd1;
        tick();
        start = 1'b0;
        wait_done(30);
        check("resume_count", {117'd0, word_count}, {117'd0, 16'd1});

        // Zero-length run.
        start = 1'b1; num_words = 16'd0;
        tick();
        start = 1'b0;
        check("zero_done",  {132'd0, done}, {132'd0, 1'b1});
        check("zero_busy",  {132'd0, busy}, '0);
        check("zero_valid", {132'd0, s_if.out_valid}, '0);
        check("zero_count", {117'd0, word_count}, '0);

        // seed_load wins over start in the same cycle.
        seed_load = 1'b1; seed_val = 32'h1234_5678; start = 1'b1; num_words = 16'd1;
        tick();
        seed_load = 1'b0; start = 1'b0;
        check("sl_rng",  {101'd0, rng_state}, {101'd0, 32'h1234_5678});
        check("sl_done", {132'd0, done}, '0);
        tick();
        check("sl_busy", {132'd0, busy}, '0);

        // start during PRESENT is ignored.
        model_state = 32'h1234_5678;
        push_words(1);
        s_if.out_ready = 1'b0;
        start = 1'b1; num_words = 16'd1;
        tick();
        start = 1'b0;
        wait_valid(20);
        start = 1'b1; num_words = 16'd5;
        tick();
        start = 1'b0;
        check("ign_busy",  {132'd0, busy}, {132'd0, 1'b1});
        check("ign_valid", {132'd0, s_if.out_valid}, {132'd0, 1'b1});
        s_if.out_ready = 1'b1;
        wait_done(20);
        check("ign_count", {117'd0, word_count}, {117'd0, 16'd1});
        check("ign_drained", OUT_W'(exp_q.size()), '0);

        // Asynchronous reset while a word is presented.
        s_if.out_ready = 1'b0;
        start = 1'b1; num_words = 16'd2;
        tick();
        start = 1'b0;
        wait_valid(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data",  s_if.out_data, '0);
        check("arst_valid", {132'd0, s_if.out_valid}, '0);
        check("arst_busy",  {132'd0, busy}, '0);
        check("arst_done",  {132'd0, done}, '0);
        check("arst_count", {117'd0, word_count}, '0);
        check("arst_rng",   {101'd0, rng_state}, {101'd0, DEF_SEED});
        tick();
        rst_n = 1'b1;
        tick();

        // 32-bit instance: one LCG step per word.
        seed_load32 = 1'b1; seed_val32 = 32'd0;
        tick();
        seed_load32 = 1'b0;
        exp32_q.push_back(32'h0000_3039);
        exp32_q.push_back(32'hD3DC_167E);
        exp32_q.push_back(lcg(32'hD3DC_167E));
        s32_if.out_ready = 1'b1;
        start32 = 1'b1; num_words32 = 16'd3;
        tick();
        start32 = 1'b0;
        tick();
        check("w32_valid", {132'd0, s32_if.out_valid}, {132'd0, 1'b1});
        check("w32_rng",   {101'd0, rng_state32}, {101'd0, 32'h0000_3039});
        for (int i = 0; i < 20 && !done32; i++) tick();
        check("w32_done",    {132'd0, done32}, {132'd0, 1'b1});
        check("w32_count",   {117'd0, word_count32}, {117'd0, 16'd3});
        check("w32_drained", OUT_W'(exp32_q.size()), '0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
